// File: rtl/spram_fifo_pkg.sv
// Shared defaults and types for the single-port-RAM backed sample FIFO.
// Optional status flags are enabled by defining SPRAM_FIFO_STATUS_EN.
package spram_fifo_pkg;

   localparam int ADDR_WIDTH_DEF = 9;
   localparam int DATA_WIDTH_DEF = 16;
   localparam int RD_LATENCY_DEF = 2;
   localparam int OUT_DEPTH      = RD_LATENCY_DEF + 2;

   // Which side wins the next cycle where both write and read want the RAM.
   typedef enum logic {
      PRIO_WR = 1'b0,
      PRIO_RD = 1'b1
   } prio_t;

   // The output buffer must absorb every read in flight plus two held samples.
   function automatic int out_depth(input int rd_latency);
      return rd_latency + 2;
   endfunction

endpackage

// File: rtl/spram_fifo_outbuf.sv
// Small register FIFO that holds samples returned by the RAM until the
// consumer takes them; head entry is always visible on head_data.
module spram_fifo_outbuf
   import spram_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = OUT_DEPTH,
   parameter int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [CNT_W-1:0]      count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_idx;
   logic [PTR_W-1:0]      rd_idx;

   function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
      return (idx == PTR_W'(DEPTH - 1)) ? '0 : idx + PTR_W'(1);
   endfunction

   // Storage is cleared on reset so the head reads as zero until refilled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_idx] <= push_data;
            wr_idx      <= next_idx(wr_idx);
         end
         if (pop) rd_idx <= next_idx(rd_idx);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign head_data = mem[rd_idx];

endmodule

// File: rtl/spram_sample_fifo.sv
// Sample FIFO storing data in an external single-port RAM, sharing the port
// between writes and reads. Status flags exist only with SPRAM_FIFO_STATUS_EN.
module spram_sample_fifo
   import spram_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int RD_LATENCY = RD_LATENCY_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ready,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_ready,
   output logic [ADDR_WIDTH+1:0] level,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic                  ram_wr_en,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  ovf_flag,
   output logic                  udf_flag,
   input  logic                  flag_clr
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int OBUF  = out_depth(RD_LATENCY);
   localparam int CNT_W = $clog2(OBUF + 1);
   localparam int LVL_W = ADDR_WIDTH + 2;

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH:0]   ram_cnt;
   logic [RD_LATENCY-1:0] rd_pipe;
   logic [CNT_W-1:0]      inflight;
   logic [CNT_W-1:0]      out_occ;
   prio_t                 prio;
   logic                  run;
   logic                  full;
   logic                  rd_req;
   logic                  wr_fire;
   logic                  rd_issue;
   logic                  contention;
   logic                  take;

   // A read is only requested if the output buffer can hold it on return,
   // so captured samples never need back-pressure.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(rd_pipe[i]);
   end

   assign full       = (ram_cnt == (ADDR_WIDTH + 1)'(DEPTH));
   assign rd_req     = (ram_cnt != '0) &&
                       ((LVL_W'(out_occ) + LVL_W'(inflight)) < LVL_W'(OBUF));
   assign wr_ready   = run && !full && (!rd_req || (prio == PRIO_WR));
   assign wr_fire    = wr_valid && wr_ready;
   assign rd_issue   = rd_req && !wr_fire;
   assign contention = run && wr_valid && !full && rd_req;
   assign take       = rd_valid && rd_ready;

   assign ram_wr_en   = wr_fire;
   assign ram_wr_data = wr_data;
   assign ram_addr    = wr_fire ? wr_ptr : (rd_issue ? rd_ptr : addr_q);

   // run delays write acceptance until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run     <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         addr_q  <= '0;
         ram_cnt <= '0;
         rd_pipe <= '0;
         prio    <= PRIO_WR;
      end else begin
         run     <= 1'b1;
         addr_q  <= ram_addr;
         rd_pipe <= (rd_pipe << 1) | RD_LATENCY'(rd_issue);
         ram_cnt <= ram_cnt + (ADDR_WIDTH + 1)'(wr_fire) - (ADDR_WIDTH + 1)'(rd_issue);
         if (wr_fire)  wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (rd_issue) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         if (contention) prio <= (prio == PRIO_WR) ? PRIO_RD : PRIO_WR;
      end
   end

   spram_fifo_outbuf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (OBUF),
      .CNT_W      (CNT_W)
   ) u_outbuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rd_pipe[RD_LATENCY-1]),
      .push_data (ram_rd_data),
      .pop       (take),
      .head_data (rd_data),
      .count     (out_occ)
   );

   assign rd_valid = (out_occ != '0);
   assign level    = LVL_W'(ram_cnt) + LVL_W'(inflight) + LVL_W'(out_occ);

`ifdef SPRAM_FIFO_STATUS_EN
   logic ovf_q;
   logic udf_q;

   // Sticky error flags; a new event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (wr_valid && full)       ovf_q <= 1'b1;
         else if (flag_clr)          ovf_q <= 1'b0;
         if (rd_ready && !rd_valid)  udf_q <= 1'b1;
         else if (flag_clr)          udf_q <= 1'b0;
      end
   end

   assign ovf_flag = ovf_q;
   assign udf_flag = udf_q;
`else
   logic unused_flag_clr;
   assign unused_flag_clr = flag_clr;
   assign ovf_flag = 1'b0;
   assign udf_flag = 1'b0;
`endif

endmodule
